// File: rtl/spectro_pkg.sv
// Shared constants, deserializer state type and parity helper.
// Optional parity support is compiled in with PARITY_CHECK_EN.
package spectro_pkg;

   localparam int TIME_WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
`ifdef PARITY_CHECK_EN
      , ST_PARITY = 2'd2
`endif
   } deser_state_t;

`ifdef PARITY_CHECK_EN
   // XOR-reduce; callers zero-extend narrower words, which leaves parity unchanged
   function automatic logic word_parity(input logic [63:0] value);
      return ^value;
   endfunction
`endif

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out register with bit-position counter, LSB first.
// load restarts a frame at bit 0; shift writes bit [counter] and advances.
module sipo_shift_reg #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic              serial_in,
   output logic [WORD_W-1:0] word,
   output logic [CNT_W-1:0]  bit_cnt
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   logic [WORD_W-1:0] shift_r;
   logic [CNT_W-1:0]  cnt_r;

   // Capture serial bits at the counter position; counter wraps after the last bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_r <= '0;
         cnt_r   <= '0;
      end else if (load) begin
         shift_r <= {{(WORD_W-1){1'b0}}, serial_in};
         cnt_r   <= CNT_W'(1);
      end else if (shift) begin
         shift_r[cnt_r] <= serial_in;
         cnt_r          <= (cnt_r == LAST_BIT) ? '0 : cnt_r + CNT_W'(1);
      end
   end

   assign word    = shift_r;
   assign bit_cnt = cnt_r;

endmodule

// File: rtl/serial_time_deserializer.sv
// Frame FSM, output holding register and valid/ready handshake around sipo_shift_reg.
// Define PARITY_CHECK_EN to append a checked even-parity bit to every frame.
module serial_time_deserializer
   import spectro_pkg::*;
#(
   parameter int WORD_W = TIME_WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              frame_start,
   output logic [WORD_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              overrun,
   output logic              frame_err
`ifdef PARITY_CHECK_EN
   , output logic            parity_err
`endif
);

   localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   deser_state_t      state_r, state_nxt_s;
   logic              load_s, shift_s, complete_s, frame_err_s;
   logic [WORD_W-1:0] word_s, complete_word_s;
   logic [CNT_W-1:0]  bit_cnt_s;
   logic [WORD_W-1:0] data_out_r;
   logic              data_valid_r, overrun_r, frame_err_r;
`ifdef PARITY_CHECK_EN
   logic              parity_err_r;
   logic              parity_bad_s;
`endif

   sipo_shift_reg #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_sipo (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s),
      .shift     (shift_s),
      .serial_in (serial_in),
      .word      (word_s),
      .bit_cnt   (bit_cnt_s)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and frame control; a frame_start outside IDLE always restarts the frame
   always_comb begin
      state_nxt_s     = state_r;
      load_s          = 1'b0;
      shift_s         = 1'b0;
      complete_s      = 1'b0;
      frame_err_s     = 1'b0;
      complete_word_s = word_s;
      case (state_r)
         ST_IDLE: begin
            if (frame_start) begin
               load_s      = 1'b1;
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (frame_start) begin
               load_s      = 1'b1;
               frame_err_s = 1'b1;
               state_nxt_s = ST_SHIFT;
            end else begin
               shift_s = 1'b1;
               if (bit_cnt_s == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                  state_nxt_s = ST_PARITY;
`else
                  // Last bit bypasses the shift register so the word lands this edge
                  complete_s                  = 1'b1;
                  complete_word_s[WORD_W-1]   = serial_in;
                  state_nxt_s                 = ST_IDLE;
`endif
               end else begin
                  state_nxt_s = ST_SHIFT;
               end
            end
         end
`ifdef PARITY_CHECK_EN
         ST_PARITY: begin
            if (frame_start) begin
               load_s      = 1'b1;
               frame_err_s = 1'b1;
               state_nxt_s = ST_SHIFT;
            end else begin
               complete_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end
         end
`endif
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

`ifdef PARITY_CHECK_EN
   assign parity_bad_s = word_parity(64'(word_s)) ^ serial_in;
`endif

   // Output holding register: a new word is dropped only when the old one is not taken this edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_r   <= '0;
         data_valid_r <= 1'b0;
         overrun_r    <= 1'b0;
         frame_err_r  <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_r <= 1'b0;
`endif
      end else begin
         overrun_r   <= 1'b0;
         frame_err_r <= frame_err_s;
`ifdef PARITY_CHECK_EN
         parity_err_r <= complete_s & parity_bad_s;
`endif
         if (complete_s) begin
            if (data_valid_r && !data_ready) begin
               overrun_r <= 1'b1;
            end else begin
               data_out_r   <= complete_word_s;
               data_valid_r <= 1'b1;
            end
         end else if (data_valid_r && data_ready) begin
            data_valid_r <= 1'b0;
         end
      end
   end

   assign data_out   = data_out_r;
   assign data_valid = data_valid_r;
   assign overrun    = overrun_r;
   assign frame_err  = frame_err_r;
`ifdef PARITY_CHECK_EN
   assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_serial_time_deserializer.sv
// Directed self-checking bench for serial_time_deserializer.
// Parity scenarios are compiled in when PARITY_CHECK_EN is defined.
module tb_serial_time_deserializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        serial_in;
   logic        frame_start;
   logic [31:0] data_out;
   logic        data_valid;
   logic        data_ready;
   logic        overrun;
   logic        frame_err;
`ifdef PARITY_CHECK_EN
   logic        parity_err;
`endif

   int checks = 0;
   int errors = 0;
   int ov_cnt = 0;
   int fe_cnt = 0;
   int base;

   serial_time_deserializer #(.WORD_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .serial_in   (serial_in),
      .frame_start (frame_start),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .overrun     (overrun),
      .frame_err   (frame_err)
`ifdef PARITY_CHECK_EN
      , .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic fs, input logic b);
      frame_start = fs;
      serial_in   = b;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] w, input int first, input int last);
      for (int i = first; i <= last; i++) drive(i == 0, w[i]);
   endtask

   task automatic send_par(input logic p);
`ifdef PARITY_CHECK_EN
      drive(1'b0, p);
`else
      if (p === 1'bx) $display("unused parity argument");
`endif
   endtask

   initial begin
      reset       = 1'b1;
      serial_in   = 1'b0;
      frame_start = 1'b0;
      data_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_data_out", data_out, 32'h0);
      chk("reset_valid", {31'd0, data_valid}, 32'd0);
      chk("reset_overrun", {31'd0, overrun}, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      drive(1'b0, 1'b1);

      // Single word, consumer always ready
      data_ready = 1'b1;
      send_bits(32'hDEADBEEF, 0, 30);
      chk("deadbeef_not_early", {31'd0, data_valid}, 32'd0);
      send_bits(32'hDEADBEEF, 31, 31);
      send_par(1'b0);
      chk("deadbeef_valid", {31'd0, data_valid}, 32'd1);
      chk("deadbeef_data", data_out, 32'hDEADBEEF);
      drive(1'b0, 1'b0);
      chk("deadbeef_one_cycle", {31'd0, data_valid}, 32'd0);

      // Back-to-back words with a stalled consumer
      data_ready = 1'b0;
      send_bits(32'h00000001, 0, 31);
      send_par(1'b1);
      chk("first_valid", {31'd0, data_valid}, 32'd1);
      base = ov_cnt;
      send_bits(32'h80000000, 0, 31);
      send_par(1'b1);
      chk("overrun_pulse", {31'd0, overrun}, 32'd1);
      chk("overrun_keep_data", data_out, 32'h00000001);
      drive(1'b0, 1'b0);
      chk("overrun_cleared", {31'd0, overrun}, 32'd0);
      chk("overrun_count", ov_cnt - base, 32'd1);
      data_ready = 1'b1;
      drive(1'b0, 1'b0);
      chk("stall_consumed", {31'd0, data_valid}, 32'd0);

      // Frame restart at bit 10
      base = fe_cnt;
      send_bits(32'hFFFFFFFF, 0, 9);
      send_bits(32'h12345678, 0, 0);
      chk("frame_err_pulse", {31'd0, frame_err}, 32'd1);
      send_bits(32'h12345678, 1, 31);
      send_par(1'b1);
      chk("restart_data", data_out, 32'h12345678);
      chk("restart_valid", {31'd0, data_valid}, 32'd1);
      drive(1'b0, 1'b0);
      chk("frame_err_count", fe_cnt - base, 32'd1);

      // Handshake on the same edge as a new completion
      data_ready = 1'b0;
      send_bits(32'h0000FFFF, 0, 31);
      send_par(1'b0);
      base = ov_cnt;
      send_bits(32'hA5A5A5A5, 0, 30);
`ifdef PARITY_CHECK_EN
      send_bits(32'hA5A5A5A5, 31, 31);
      data_ready = 1'b1;
      drive(1'b0, 1'b0);
`else
      data_ready = 1'b1;
      send_bits(32'hA5A5A5A5, 31, 31);
`endif
      chk("same_edge_valid", {31'd0, data_valid}, 32'd1);
      chk("same_edge_data", data_out, 32'hA5A5A5A5);
      chk("same_edge_no_overrun", {31'd0, overrun}, 32'd0);
      drive(1'b0, 1'b0);
      chk("same_edge_ov_count", ov_cnt - base, 32'd0);
      chk("same_edge_consumed", {31'd0, data_valid}, 32'd0);

      // frame_start coincident with the last bit aborts the word
      base = fe_cnt;
      send_bits(32'h0F0F0F0F, 0, 30);
      send_bits(32'h00FF00FF, 0, 0);
      chk("last_bit_abort_err", {31'd0, frame_err}, 32'd1);
      chk("last_bit_abort_no_word", {31'd0, data_valid}, 32'd0);
      send_bits(32'h00FF00FF, 1, 31);
      send_par(1'b0);
      chk("after_abort_data", data_out, 32'h00FF00FF);
      drive(1'b0, 1'b0);
      chk("last_bit_abort_count", fe_cnt - base, 32'd1);

      // Reset in the middle of a word
      send_bits(32'hFFFFFFFF, 0, 19);
      reset = 1'b1;
      #2;
      chk("midreset_data_out", data_out, 32'h0);
      chk("midreset_valid", {31'd0, data_valid}, 32'd0);
      chk("midreset_overrun", {31'd0, overrun}, 32'd0);
      chk("midreset_frame_err", {31'd0, frame_err}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 40; i++) drive(1'b0, 1'b1);
      chk("no_frame_no_word", {31'd0, data_valid}, 32'd0);
      send_bits(32'hCAFEF00D, 0, 31);
      send_par(1'b0);
      chk("post_reset_data", data_out, 32'hCAFEF00D);
      chk("post_reset_valid", {31'd0, data_valid}, 32'd1);
      drive(1'b0, 1'b0);

`ifdef PARITY_CHECK_EN
      // Even parity: 0x00000003 needs parity bit 0
      send_bits(32'h00000003, 0, 31);
      send_par(1'b1);
      chk("parity_bad_pulse", {31'd0, parity_err}, 32'd1);
      chk("parity_bad_delivered", {31'd0, data_valid}, 32'd1);
      chk("parity_bad_data", data_out, 32'h00000003);
      drive(1'b0, 1'b0);
      chk("parity_pulse_ends", {31'd0, parity_err}, 32'd0);
      send_bits(32'h00000003, 0, 31);
      send_par(1'b0);
      chk("parity_good_no_err", {31'd0, parity_err}, 32'd0);
      chk("parity_good_valid", {31'd0, data_valid}, 32'd1);
      drive(1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
